// File: rtl/vga_scanout.sv
// vga_scanout: reads the 160x120x3 framebuffer through a 1-clock-latency
// synchronous port and drives 640x480@60 VGA pins from the 50 MHz clock.
// Every framebuffer word is replicated into a 4x4 block of screen pixels.
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int FB_WIDTH    = 160,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        frame_start,
  output logic        vblank,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [14:0] FB_W   = 15'(FB_WIDTH);

  logic       pix_phase_q, pix_phase_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_n_q, blank_n_d;
  logic [9:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       fs_q, fs_d;
  logic       vblank_q, vblank_d;

  logic       tick, active, h_end, v_end;
  logic [9:0] fb_x, fb_y;

  // A tick is the clock edge that ends the high half of the pixel clock.
  assign tick   = pix_phase_q;
  assign h_end  = (h_cnt_q == H_LAST);
  assign v_end  = (v_cnt_q == V_LAST);
  assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

  // Address follows the counters, so it is stable for a whole pixel period;
  // the RAM samples it mid-period and data is back before the next tick.
  assign fb_x    = h_cnt_q >> SCALE_SHIFT;
  assign fb_y    = v_cnt_q >> SCALE_SHIFT;
  assign rd_addr = active ? (15'(fb_y) * FB_W + 15'(fb_x)) : 15'd0;

  // Next-state: counters advance and pin registers reload only on ticks.
  always_comb begin
    pix_phase_d = ~pix_phase_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    blank_n_d   = blank_n_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    vblank_d    = vblank_q;
    fs_d        = 1'b0;
    if (tick) begin
      h_cnt_d = h_end ? 10'd0 : h_cnt_q + 10'd1;
      if (h_end) v_cnt_d = v_end ? 10'd0 : v_cnt_q + 10'd1;
      // Colour and sync both come from the pre-tick counter sample.
      blank_n_d = active;
      r_d       = active ? {10{rd_data[2]}} : 10'd0;
      g_d       = active ? {10{rd_data[1]}} : 10'd0;
      b_d       = active ? {10{rd_data[0]}} : 10'd0;
      hs_d      = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
      vs_d      = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
      vblank_d  = (v_cnt_d >= V_ACT);
      fs_d      = h_end && v_end;
    end
  end

  // State and pin registers with asynchronous reset to idle pin levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_phase_q <= 1'b0;
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 10'd0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_n_q   <= 1'b0;
      r_q         <= 10'd0;
      g_q         <= 10'd0;
      b_q         <= 10'd0;
      fs_q        <= 1'b0;
      vblank_q    <= 1'b0;
    end else begin
      pix_phase_q <= pix_phase_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_n_q   <= blank_n_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      fs_q        <= fs_d;
      vblank_q    <= vblank_d;
    end
  end

  assign VGA_CLK     = pix_phase_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign frame_start = fs_q;
  assign vblank      = vblank_q;

endmodule
